// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data-memory bus arbiter: FSM encodings and master indices.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_M0  = 2'd1,
    OWN_M1  = 2'd2,
    LOCK_M1 = 2'd3
  } bus_state_e;

  localparam logic M_CPU   = 1'b0;
  localparam logic M_STACK = 1'b1;

endpackage

// File: rtl/data_bus_mux.sv
// Steers the granted master's transfer onto the data-memory port.
// Purely combinational; everything is forced to zero when nobody holds a grant.
module data_bus_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              m0_grant_i,
  input  logic              m0_wr_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m1_grant_i,
  input  logic              m1_wr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic              mem_rd_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  always_comb begin
    mem_addr_o  = '0;
    mem_wr_o    = 1'b0;
    mem_rd_o    = 1'b0;
    mem_wdata_o = '0;
    if (m1_grant_i) begin
      mem_addr_o  = m1_addr_i;
      mem_wr_o    = m1_wr_i;
      mem_rd_o    = ~m1_wr_i;
      mem_wdata_o = m1_wdata_i;
    end else if (m0_grant_i) begin
      mem_addr_o  = m0_addr_i;
      mem_wr_o    = m0_wr_i;
      mem_rd_o    = ~m0_wr_i;
      mem_wdata_o = m0_wdata_i;
    end
  end

  assign rdata_o = mem_rd_o ? mem_rdata_i : '0;

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data-memory arbiter (CPU datapath vs stack controller) with registered
// one-cycle grants, round-robin priority and a stack lock for multi-transfer sequences.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_grant,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  bus_state_e state_q, state_d;
  logic       prio_q, prio_d;   // master that wins a simultaneous request
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= M_STACK;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  // The lock bit is sampled together with each m1 grant: a transfer requested with
  // m1_lock=0 is the last one of the sequence and releases the bus right after it.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    if (state_q == LOCK_M1) begin
      if (m1_req) begin
        gnt1_d  = 1'b1;
        prio_d  = M_CPU;
        state_d = m1_lock ? LOCK_M1 : OWN_M1;
      end else if (!m1_lock) begin
        state_d = IDLE;
      end
    end else begin
      if (m1_req && (!m0_req || prio_q == M_STACK)) begin
        gnt1_d  = 1'b1;
        prio_d  = M_CPU;
        state_d = m1_lock ? LOCK_M1 : OWN_M1;
      end else if (m0_req) begin
        gnt0_d  = 1'b1;
        prio_d  = M_STACK;
        state_d = OWN_M0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign m0_grant = gnt0_q;
  assign m1_grant = gnt1_q;

  data_bus_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .m0_grant_i (gnt0_q),
    .m0_wr_i    (m0_wr),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m1_grant_i (gnt1_q),
    .m1_wr_i    (m1_wr),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_addr_o (mem_addr),
    .mem_wr_o   (mem_wr),
    .mem_rd_o   (mem_rd),
    .mem_wdata_o(mem_wdata),
    .rdata_o    (rdata)
  );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter.
module tb_data_bus_arbiter;
  import data_bus_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic       m0_req, m0_wr, m0_grant;
  logic [7:0] m0_addr, m0_wdata;
  logic       m1_req, m1_lock, m1_wr, m1_grant;
  logic [7:0] m1_addr, m1_wdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic       mem_wr, mem_rd;

  int checks = 0;
  int errors = 0;

  data_bus_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_grant(m0_grant),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_grant(m1_grant),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata)
  );

  // Memory model: 0x10 holds 0x5A, every other location holds addr ^ 0xA5.
  assign mem_rdata = (mem_addr == 8'h10) ? 8'h5A : (mem_addr ^ 8'hA5);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    m0_req = 1; m1_req = 1; m1_lock = 1;
    tick();
    tick();
    checks++;
    if ({m1_grant, m0_grant} !== 2'b00) begin
      errors++; $display("FAIL reset_grants: got %b expected 00", {m1_grant, m0_grant});
    end
    checks++;
    if ({mem_wr, mem_rd, mem_addr, mem_wdata, rdata} !== 26'd0) begin
      errors++; $display("FAIL reset_mem_port: wr=%b rd=%b addr=%h wdata=%h rdata=%h expected all 0",
                         mem_wr, mem_rd, mem_addr, mem_wdata, rdata);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
    end
    idle_inputs();
    rst = 0;
    tick();
    checks++;
    if ({m1_grant, m0_grant} !== 2'b00) begin
      errors++; $display("FAIL reset_release_grants: got %b expected 00", {m1_grant, m0_grant});
    end
  endtask

  task automatic test_m0_read();
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 8'h10;
    tick();
    checks++;
    if ({m1_grant, m0_grant} !== 2'b01) begin
      errors++; $display("FAIL m0_read_grant: got %b expected 01", {m1_grant, m0_grant});
    end
    checks++;
    if ({mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
      errors++; $display("FAIL m0_read_strobe: rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=10",
                         mem_rd, mem_wr, mem_addr);
    end
    checks++;
    if (rdata !== 8'h5A) begin
      errors++; $display("FAIL m0_read_rdata: got %h expected 5a", rdata);
    end
    m0_req = 0;
    tick();
    checks++;
    if ({m0_grant, mem_rd, rdata} !== 10'd0) begin
      errors++; $display("FAIL m0_read_after: grant=%b rd=%b rdata=%h expected 0", m0_grant, mem_rd, rdata);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_req = 1; m0_wr = 1; m0_addr = 8'h20; m0_wdata = 8'h11;
    m1_req = 1; m1_wr = 1; m1_addr = 8'h30; m1_wdata = 8'h22;
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_wr, mem_addr, mem_wdata} !== {2'b10, 1'b1, 8'h30, 8'h22}) begin
      errors++; $display("FAIL simul_first: gnt=%b wr=%b addr=%h wdata=%h expected gnt=10 wr=1 addr=30 wdata=22",
                         {m1_grant, m0_grant}, mem_wr, mem_addr, mem_wdata);
    end
    m1_req = 0;
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_wr, mem_addr, mem_wdata} !== {2'b01, 1'b1, 8'h20, 8'h11}) begin
      errors++; $display("FAIL simul_second: gnt=%b wr=%b addr=%h wdata=%h expected gnt=01 wr=1 addr=20 wdata=11",
                         {m1_grant, m0_grant}, mem_wr, mem_addr, mem_wdata);
    end
    m0_req = 0;
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_wr} !== 3'b000) begin
      errors++; $display("FAIL simul_done: gnt=%b wr=%b expected 00 0", {m1_grant, m0_grant}, mem_wr);
    end
  endtask

  task automatic test_lock_push();
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 8'h40;
    m1_req = 1; m1_lock = 1; m1_wr = 1; m1_addr = 8'hFD; m1_wdata = 8'h23;
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_wr, mem_addr, mem_wdata} !== {2'b10, 1'b1, 8'hFD, 8'h23}) begin
      errors++; $display("FAIL push_first: gnt=%b wr=%b addr=%h wdata=%h expected gnt=10 wr=1 addr=fd wdata=23",
                         {m1_grant, m0_grant}, mem_wr, mem_addr, mem_wdata);
    end
    m1_lock = 0; m1_addr = 8'hFC; m1_wdata = 8'h41;
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_wr, mem_addr, mem_wdata} !== {2'b10, 1'b1, 8'hFC, 8'h41}) begin
      errors++; $display("FAIL push_second: gnt=%b wr=%b addr=%h wdata=%h expected gnt=10 wr=1 addr=fc wdata=41",
                         {m1_grant, m0_grant}, mem_wr, mem_addr, mem_wdata);
    end
    m1_req = 0;
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_rd, mem_addr, rdata} !== {2'b01, 1'b1, 8'h40, 8'hE5}) begin
      errors++; $display("FAIL push_then_m0: gnt=%b rd=%b addr=%h rdata=%h expected gnt=01 rd=1 addr=40 rdata=e5",
                         {m1_grant, m0_grant}, mem_rd, mem_addr, rdata);
    end
    m0_req = 0;
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    m0_req = 1; m0_wr = 1; m0_addr = 8'h01; m0_wdata = 8'hA0;
    m1_req = 1; m1_wr = 1; m1_addr = 8'h02; m1_wdata = 8'hB0;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] exp_gnt;
      logic [7:0] exp_addr;
      tick();
      exp_gnt  = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr = (k % 2 == 0) ? 8'h02 : 8'h01;
      checks++;
      if ({m1_grant, m0_grant} !== exp_gnt || mem_addr !== exp_addr) begin
        errors++; $display("FAIL alternate_%0d: gnt=%b addr=%h expected gnt=%b addr=%h",
                           k, {m1_grant, m0_grant}, mem_addr, exp_gnt, exp_addr);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_m0_pulse_during_lock();
    do_reset();
    m1_req = 1; m1_lock = 1; m1_wr = 1; m1_addr = 8'h50; m1_wdata = 8'h99;
    tick();
    checks++;
    if ({m1_grant, m0_grant} !== 2'b10) begin
      errors++; $display("FAIL pulse_lock_grant: got %b expected 10", {m1_grant, m0_grant});
    end
    m1_req = 0;
    m0_req = 1; m0_wr = 1; m0_addr = 8'h60; m0_wdata = 8'h77;
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_wr, mem_rd} !== 4'b0000) begin
      errors++; $display("FAIL pulse_lock_idle: gnt=%b wr=%b rd=%b expected all 0",
                         {m1_grant, m0_grant}, mem_wr, mem_rd);
    end
    m0_req = 0;
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_wr, mem_rd} !== 4'b0000) begin
      errors++; $display("FAIL pulse_no_m0: gnt=%b wr=%b rd=%b expected all 0",
                         {m1_grant, m0_grant}, mem_wr, mem_rd);
    end
    checks++;
    if (dut.state_q !== LOCK_M1) begin
      errors++; $display("FAIL pulse_still_locked: state=%0d expected LOCK_M1", dut.state_q);
    end
    m1_lock = 0;
    tick();
    checks++;
    if (dut.state_q !== IDLE || {m1_grant, m0_grant} !== 2'b00) begin
      errors++; $display("FAIL pulse_unlock: state=%0d gnt=%b expected IDLE 00", dut.state_q, {m1_grant, m0_grant});
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    m1_req = 1; m1_lock = 1; m1_wr = 1; m1_addr = 8'hFD; m1_wdata = 8'h23;
    tick();
    m1_req = 0;
    tick();
    checks++;
    if (dut.state_q !== LOCK_M1 || {m1_grant, m0_grant} !== 2'b00) begin
      errors++; $display("FAIL midlock_hold: state=%0d gnt=%b expected LOCK_M1 00", dut.state_q, {m1_grant, m0_grant});
    end
    rst = 1; m1_req = 1; m0_req = 1;
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_wr, mem_rd} !== 4'b0000) begin
      errors++; $display("FAIL midlock_reset_strobes: gnt=%b wr=%b rd=%b expected all 0",
                         {m1_grant, m0_grant}, mem_wr, mem_rd);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL midlock_reset_state: got %0d expected IDLE", dut.state_q);
    end
    rst = 0;
    idle_inputs();
    tick();
    checks++;
    if ({m1_grant, m0_grant, mem_wr, mem_rd} !== 4'b0000) begin
      errors++; $display("FAIL midlock_after: gnt=%b wr=%b rd=%b expected all 0",
                         {m1_grant, m0_grant}, mem_wr, mem_rd);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_m0_read();
    test_simultaneous();
    test_lock_push();
    test_alternate();
    test_m0_pulse_during_lock();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: data-memory address width.
REQ-002 Parameter DATA_W, default 8: data-memory word width.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0_req  input  1  CPU datapath bus request (single transfer).
REQ-006 m0_wr  input  1  CPU transfer direction: 1 write, 0 read.
REQ-007 m0_addr  input  ADDR_W  CPU address; stable while m0_req=1.
REQ-008 m0_wdata  input  DATA_W  CPU write data.
REQ-009 m0_grant  output  1  CPU transfer executes this cycle.
REQ-010 m1_req  input  1  stack controller bus request.
REQ-011 m1_lock  input  1  stack controller holds bus across consecutive transfers (push/pop sequence).
REQ-012 m1_wr  input  1  stack transfer direction.
REQ-013 m1_addr  input  ADDR_W  stack address.
REQ-014 m1_wdata  input  DATA_W  stack write data.
REQ-015 m1_grant  output  1  stack transfer executes this cycle.
REQ-016 mem_addr  output  ADDR_W  address to data memory.
REQ-017 mem_wr  output  1  memory write strobe.
REQ-018 mem_rd  output  1  memory read strobe.
REQ-019 mem_wdata  output  DATA_W  write data to memory.
REQ-020 mem_rdata  input  DATA_W  memory read data, combinational from mem_addr.
REQ-021 rdata  output  DATA_W  read data returned to granted master, valid in grant cycle.

Function
REQ-022 The FSM SHALL have states IDLE, OWN_M0, OWN_M1, LOCK_M1; one-hot or binary encoding at implementer's choice.
REQ-023 Grants SHALL be registered: a request seen at edge N yields grant in cycle N+1; minimum latency 1 cycle, each grant lasts exactly 1 cycle per transfer.
REQ-024 At most one of m0_grant, m1_grant SHALL be 1 in any cycle.
REQ-025 Arbitration SHALL be round-robin: on simultaneous requests, the master not granted most recently wins; after reset m1 has priority.
REQ-026 In a grant cycle, mem_addr/mem_wdata/mem_wr/mem_rd SHALL be muxed combinationally from the granted master; mem_wr=wr, mem_rd=~wr.
REQ-027 Outside grant cycles mem_wr=0, mem_rd=0, mem_addr=0, mem_wdata=0, rdata=0.
REQ-028 rdata SHALL equal mem_rdata during a read grant cycle.
REQ-029 If m1_lock=1 at a m1 grant edge, the FSM SHALL enter LOCK_M1 and grant only m1 until m1_lock=0; m0 waits regardless of round-robin.
REQ-030 In LOCK_M1, back-to-back m1 requests SHALL be granted every cycle (no idle cycle between push flag and push PC).
REQ-031 In LOCK_M1, if m1_req=0 and m1_lock=1 the bus SHALL stay owned and idle; if m1_lock drops, return to IDLE next edge.
REQ-032 A master deasserting req before its grant SHALL receive no grant; no transfer SHALL be issued.
REQ-033 A master holding req continuously SHALL receive one grant per arbitration round; m0 starvation bound is one m1 lock sequence plus 1 grant.

Reset
REQ-034 On rst=1 at a rising edge: state=IDLE, m0_grant=0, m1_grant=0, round-robin pointer = m1-first.
REQ-035 Reset mid-lock SHALL abandon the sequence; no memory strobe SHALL be driven in the cycle after reset.

Structure
REQ-036 State encodings and master index constants (M_CPU=0, M_STACK=1) SHALL reside in the shared CPU package.
REQ-037 The datapath mux SHALL be a sub-module data_bus_mux; FSM and round-robin pointer stay in data_bus_arbiter.

Verification
REQ-038 m0_req only, read addr 0x10, mem holds 0x5A -> m0_grant one cycle after req, rdata=0x5A, mem_rd=1.
REQ-039 m0 and m1 req same cycle after reset -> m1 granted first, m0 next cycle.
REQ-040 m1 lock push: writes 0x23 to 0xFD then 0x41 to 0xFC with m0_req held -> two consecutive m1 grants, then m0 grant.
REQ-041 Both masters hold req 8 cycles without lock -> grants alternate m1,m0,m1,m0.
REQ-042 rst asserted during LOCK_M1 between transfers -> no grant/strobe next cycle, state IDLE.
REQ-043 m0_req pulses 1 cycle while m1 owns bus -> no m0 grant, no m0 memory access.
